// File: rtl/fetch_pkg.sv
// Shared CPU definitions used by the fetch stage and its instruction buffer.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits of a target are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_inst_fifo.sv
// Instruction buffer: power-of-two circular FIFO with a synchronous flush.
// The head word reads as zero while the buffer is empty.
module inst_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    // Storage array; no reset needed since the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign data_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC and a single-outstanding-request
// memory FSM, and feeds decode from a small instruction buffer.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_en,
    input  logic [31:0] jmp_addr,
    input  logic        clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_addr,
    input  logic        ins_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q;
    logic [31:0]      pc_q;
    logic             redirect;
    logic [31:0]      target;
    logic             push;
    logic             pop;
    logic [63:0]      head;
    logic [CNT_W-1:0] fifo_cnt;

    assign redirect = jmp_en | clr;
    assign target   = align_pc(jmp_addr);

    // Requests go out combinationally so the first fetch leaves in the very
    // cycle reset is released; reset itself masks the strobe.
    assign imem_req  = rst && (state_q == ST_IDLE) && (fifo_cnt < CNT_W'(FIFO_DEPTH)) && !redirect;
    assign imem_addr = pc_q;

    assign push      = (state_q == ST_WAIT) && imem_valid && !redirect;
    assign ins_valid = (fifo_cnt != '0) && !redirect;
    assign pop       = ins_valid && ins_ready;
    assign ins       = head[31:0];
    assign ins_addr  = head[63:32];

    // Request FSM and PC: a redirect always wins; a response still in flight
    // at redirect time must be swallowed in DROP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else if (imem_req) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        pc_q    <= target;
                        state_q <= imem_valid ? ST_IDLE : ST_DROP;
                    end else if (imem_valid) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else if (imem_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    inst_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  ({pc_q, imem_data}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

endmodule
